// File: rtl/reg_bank_writer.sv
// Write side of the 16-entry register bank: byte-lane writes over valid/ready plus a sequenced bank clear.
// Optional: define REG_BANK_R0_ZERO_EN to hardwire r0 to zero.
module reg_bank_writer #(
   parameter int unsigned     WIDTH   = 16,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [3:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [1:0]       wr_be,
   output logic             wr_done,
   input  logic             clr_req,
   output logic             busy,
   output logic [WIDTH-1:0] r0,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] r4,
   output logic [WIDTH-1:0] r5,
   output logic [WIDTH-1:0] r6,
   output logic [WIDTH-1:0] r7,
   output logic [WIDTH-1:0] r8,
   output logic [WIDTH-1:0] r9,
   output logic [WIDTH-1:0] r10,
   output logic [WIDTH-1:0] r11,
   output logic [WIDTH-1:0] r12,
   output logic [WIDTH-1:0] r13,
   output logic [WIDTH-1:0] r14,
   output logic [WIDTH-1:0] r15
);

   localparam int unsigned NREG = 16;
   localparam int unsigned HALF = WIDTH / 2;
`ifdef REG_BANK_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       cnt;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             accept_c;
   logic [WIDTH-1:0] regs [NREG];

   // ready is its own flop so it can be low during and right after reset
   assign accept_c = wr_valid && ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (clr_req) state_next = CLEAR;
         CLEAR:   if (cnt == 4'd15) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // status flags are registered copies of the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt     <= 4'd0;
      end else begin
         ready_q <= (state_next == IDLE);
         busy_q  <= (state_next == CLEAR);
         done_q  <= accept_c;
         cnt     <= (state == CLEAR) ? cnt + 4'd1 : 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (R0_ZERO && i == 0) begin
               regs[i] <= regs[i];
            end else if (state == CLEAR && cnt == 4'(i)) begin
               regs[i] <= CLR_VAL;
            end else if (accept_c && wr_addr == 4'(i)) begin
               if (wr_be[0]) regs[i][HALF-1:0]     <= wr_data[HALF-1:0];
               if (wr_be[1]) regs[i][WIDTH-1:HALF] <= wr_data[WIDTH-1:HALF];
            end
         end
      end
   end

   assign wr_ready = ready_q;
   assign busy     = busy_q;
   assign wr_done  = done_q;

   assign r0  = regs[0];
   assign r1  = regs[1];
   assign r2  = regs[2];
   assign r3  = regs[3];
   assign r4  = regs[4];
   assign r5  = regs[5];
   assign r6  = regs[6];
   assign r7  = regs[7];
   assign r8  = regs[8];
   assign r9  = regs[9];
   assign r10 = regs[10];
   assign r11 = regs[11];
   assign r12 = regs[12];
   assign r13 = regs[13];
   assign r14 = regs[14];
   assign r15 = regs[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: write vector table, clear sweeps, overlap cases, async reset.
module tb_reg_bank_writer;

`ifdef REG_BANK_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        clr_req;
   logic        wr_ready;
   logic        wr_done;
   logic        busy;
   logic [15:0] rv [16];

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] val;
   } exp_t;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      logic [1:0]  be;
      logic [15:0] exp_val;
   } vec_t;

   exp_t        sbq[$];
   exp_t        sb_e;
   vec_t        vecs [8];
   logic [15:0] model [16];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   reg_bank_writer dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_done(wr_done),
      .clr_req(clr_req), .busy(busy),
      .r0(rv[0]), .r1(rv[1]), .r2(rv[2]), .r3(rv[3]), .r4(rv[4]), .r5(rv[5]),
      .r6(rv[6]), .r7(rv[7]), .r8(rv[8]), .r9(rv[9]), .r10(rv[10]), .r11(rv[11]),
      .r12(rv[12]), .r13(rv[13]), .r14(rv[14]), .r15(rv[15])
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_write(input logic [3:0] a, input logic [15:0] d,
                              input logic [1:0] be, input logic [15:0] expv);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_be    = be;
      sbq.push_back('{a, expv});
      model[a] = expv;
   endtask

   task automatic go_idle();
      @(negedge clk);
      wr_valid = 1'b0;
      clr_req  = 1'b0;
   endtask

   task automatic check_all(input string nm);
      for (int k = 0; k < 16; k++) chk($sformatf("%s_r%0d", nm, k), rv[k], model[k]);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk("wait_idle_busy", 16'(busy), 16'd0);
   endtask

   // scoreboard: each wr_done pulse retires the oldest queued write
   always @(posedge clk) begin
      #1;
      if (rst_n && wr_done) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected_done actual=1 required=0 at %0t", $time);
         end else begin
            sb_e = sbq.pop_front();
            chk($sformatf("sb_r%0d", sb_e.addr), rv[sb_e.addr], sb_e.val);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{4'h3, 16'hBEEF, 2'b11, 16'hBEEF};
      vecs[1] = '{4'h7, 16'h1234, 2'b11, 16'h1234};
      vecs[2] = '{4'h7, 16'hABCD, 2'b10, 16'hAB34};
      vecs[3] = '{4'h7, 16'h0000, 2'b00, 16'hAB34};
      vecs[4] = '{4'h7, 16'h55AA, 2'b01, 16'hABAA};
      vecs[5] = '{4'h0, 16'hFFFF, 2'b11, R0Z ? 16'h0000 : 16'hFFFF};
      vecs[6] = '{4'hF, 16'hCAFE, 2'b11, 16'hCAFE};
      vecs[7] = '{4'h3, 16'h0011, 2'b01, 16'hBE11};
      for (int k = 0; k < 16; k++) model[k] = 16'h0000;

      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 4'h0; wr_data = 16'h0; wr_be = 2'b00; clr_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 16'(wr_ready), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(wr_done), 16'd0);
      check_all("rst");
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 16'(wr_ready), 16'd1);
      chk("post_rst_busy", 16'(busy), 16'd0);

      // back-to-back table writes
      for (int i = 0; i < 8; i++) begin
         drive_write(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_val);
         tick();
         chk($sformatf("tbl%0d_done", i), 16'(wr_done), 16'd1);
         chk($sformatf("tbl%0d_val", i), rv[vecs[i].addr], vecs[i].exp_val);
      end
      go_idle();
      tick();
      chk("tbl_done_drop", 16'(wr_done), 16'd0);
      check_all("tbl");

      // fill, then single-cycle clear with a write held during the sweep
      for (int k = 0; k < 16; k++) begin
         drive_write(4'(k), 16'(16'h1111 * (k + 1)), 2'b11,
                     (R0Z && k == 0) ? 16'h0000 : 16'(16'h1111 * (k + 1)));
         tick();
      end
      go_idle();
      tick();
      check_all("fill");
      @(negedge clk);
      clr_req = 1'b1;
      tick();
      for (int cyc = 0; cyc < 16; cyc++) begin
         chk($sformatf("sw%0d_busy", cyc), 16'(busy), 16'd1);
         chk($sformatf("sw%0d_ready", cyc), 16'(wr_ready), 16'd0);
         chk($sformatf("sw%0d_done", cyc), 16'(wr_done), 16'd0);
         for (int j = 0; j < 16; j++)
            chk($sformatf("sw%0d_r%0d", cyc, j), rv[j], (j < cyc) ? 16'h0000 : model[j]);
         if (cyc == 0) begin
            @(negedge clk);
            clr_req = 1'b0;
         end
         if (cyc == 5) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 16'h5555; wr_be = 2'b11;
            sbq.push_back('{4'h5, 16'h5555});
         end
         tick();
      end
      for (int k = 0; k < 16; k++) model[k] = 16'h0000;
      chk("sw_end_busy", 16'(busy), 16'd0);
      chk("sw_end_ready", 16'(wr_ready), 16'd1);
      chk("sw_end_done", 16'(wr_done), 16'd0);
      check_all("sw_end");
      tick();
      model[5] = 16'h5555;
      chk("held_wr_done", 16'(wr_done), 16'd1);
      go_idle();
      tick();
      check_all("held_wr");

      // write and clear in the same cycle
      drive_write(4'h2, 16'h00FF, 2'b11, 16'h00FF);
      clr_req = 1'b1;
      tick();
      chk("sim_busy", 16'(busy), 16'd1);
      chk("sim_r2_c0", rv[2], 16'h00FF);
      go_idle();
      tick();
      chk("sim_r2_c1", rv[2], 16'h00FF);
      tick();
      chk("sim_r2_c2", rv[2], 16'h00FF);
      tick();
      chk("sim_r2_c3", rv[2], 16'h0000);
      chk("sim_r5_c3", rv[5], 16'h5555);
      wait_idle();
      chk("sim_ready", 16'(wr_ready), 16'd1);
      for (int k = 0; k < 16; k++) model[k] = 16'h0000;
      check_all("sim_end");

      // clr_req held high restarts the sweep
      @(negedge clk);
      clr_req = 1'b1;
      tick();
      repeat (16) tick();
      chk("lvl_gap_busy", 16'(busy), 16'd0);
      tick();
      chk("lvl_restart_busy", 16'(busy), 16'd1);
      go_idle();
      wait_idle();

      // async reset mid-sweep
      drive_write(4'h9, 16'h1234, 2'b11, 16'h1234);
      tick();
      go_idle();
      @(negedge clk);
      clr_req = 1'b1;
      tick();
      @(negedge clk);
      clr_req = 1'b0;
      repeat (5) tick();
      chk("ars_r9_before", rv[9], 16'h1234);
      chk("ars_busy_before", 16'(busy), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 16; k++) model[k] = 16'h0000;
      check_all("ars");
      chk("ars_busy", 16'(busy), 16'd0);
      chk("ars_ready", 16'(wr_ready), 16'd0);
      chk("ars_done", 16'(wr_done), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ars_rel_ready", 16'(wr_ready), 16'd1);
      chk("ars_rel_busy", 16'(busy), 16'd0);
      drive_write(4'h0, 16'hFFFF, 2'b11, R0Z ? 16'h0000 : 16'hFFFF);
      tick();
      go_idle();
      tick();
      check_all("r0_wr");

      chk("sb_drained", 16'(sbq.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
